multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Main sequencing FSM of the multicycle RV32I core. Steps each instruction through fetch/decode/execute/writeback.
//  Drives datapath mux selects, register/memory write enables and alu_op_o/op_funct7_o into alu_decoder.
//  Stalls on a single shared instruction/data memory port via a req/ready handshake.
// PARAMETERS
//  RETIRE_CNT_W  32  width of retired-instruction counter instret_o; wraps modulo 2^RETIRE_CNT_W
// PORTS
//  clk_i            in   1   core clock
//  rst_i            in   1   asynchronous reset, active-high
//  op_i             in   7   opcode from instruction register
//  funct3_i         in   3   instr[14:12]
//  funct7b5_i       in   1   instr[30]
//  zero_i           in   1   ALU zero flag
//  mem_ready_i      in   1   memory completes current access this cycle
//  mem_req_o        out  1   memory access request
//  mem_write_o      out  1   access is a store
//  adr_src_o        out  1   0: PC, 1: ALUOut as memory address
//  ir_write_o       out  1   load instruction register
//  pc_write_o       out  1   load PC from result bus
//  reg_write_o      out  1   register file write enable
//  result_src_o     out  2   00 ALUOut, 01 read data, 10 ALU result
//  alu_src_a_o      out  2   00 PC, 01 OldPC, 10 rs1 (A), 11 zero
//  alu_src_b_o      out  2   00 rs2, 01 immediate, 10 constant 4
//  alu_op_o         out  2   to alu_decoder; 11 never driven
//  op_funct7_o      out  2   {op_i[5], funct7b5_i}, always combinational passthrough
//  instr_retired_o  out  1   one-cycle pulse per completed instruction
//  instret_o        out  RETIRE_CNT_W  retired-instruction count
//  illegal_o        out  1   illegal-instruction trap flag
// BEHAVIOUR
//  - Moore FSM; state register async-reset to FETCH. While rst_i=1, every output is 0 and instret_o=0.
//  - Unlisted outputs are 0. alu_op_o defaults to 00.
//  - FETCH: mem_req=1, adr_src=0, a=00, b=10, result_src=10.
//    - If mem_ready_i=1: ir_write=1, pc_write=1, go to DECODE.
//    - Otherwise hold in FETCH; mem_req stays asserted.
//  - DECODE: a=01, b=01 (branch/jump target to ALUOut). Next state by op_i:
//    - 0000011/0100011 -> MEMADR
//    - 0110011 -> EXECR; 0010011 -> EXECI
//    - 1100011 -> BRANCH only if funct3_i is 000 or 001, otherwise illegal
//    - 1101111 -> JAL; 1100111 -> JALRADR; 0110111 -> LUI
//    - any other op_i is illegal
//  - MEMADR: a=10, b=01; next MEMREAD if op_i[5]=0, else MEMWRITE.
//  - MEMREAD: mem_req=1, adr_src=1; wait for mem_ready_i, then MEMWB.
//  - MEMWB: result_src=01, reg_write=1 -> FETCH.
//  - MEMWRITE: mem_req=1, mem_write=1, adr_src=1; wait for mem_ready_i, then FETCH.
//  - EXECR: a=10, b=00, alu_op=10 -> ALUWB.
//  - EXECI: a=10, b=01, alu_op=10 -> ALUWB.
//  - LUI: a=11, b=01 -> ALUWB.
//  - ALUWB: result_src=00, reg_write=1 -> FETCH.
//  - BRANCH: a=10, b=00, alu_op=01, result_src=00, pc_write = zero_i ^ funct3_i[0] -> FETCH.
//  - JALRADR: a=10, b=01 -> JAL.
//  - JAL: a=01, b=10, result_src=00, pc_write=1 -> ALUWB (writes OldPC+4).
//  - instr_retired_o=1 on every transition into FETCH from a non-FETCH state, except from illegal handling.
//    On the same edge instret_o increments by 1 and wraps at all-ones -> 0.
//  - mem_ready_i is ignored in states with mem_req_o=0.
//  - Latency: R/I/LUI 4 cycles, load 5, store 4, branch 3, jal 4, jalr 5 (zero-wait memory).
//  - Reset mid-instruction: abort immediately and return to FETCH; mem_req drops with no write. Restart FETCH after release.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: illegal decode -> TRAP state.
//    - TRAP is sticky until rst_i; illegal_o=1, every other output 0, no retire.
//  ILLEGAL_TRAP_EN undefined: illegal decode -> FETCH as a NOP.
//    - No retire pulse, illegal_o tied 0, TRAP state absent.
// TESTING
//  1. add (op 0110011, f7b5=1, f3=000), ready=1 -> FETCH,DECODE,EXECR,ALUWB; EXECR alu_op=10, op_funct7=11; one retire; instret 0->1.
//  2. lw with ready low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, mem_req=1, adr_src=1; MEMWB reg_write=1, result_src=01.
//  3. beq zero_i=1 -> BRANCH pc_write=1; bne zero_i=1 -> pc_write=0; both retire after 3 cycles.
//  4. jalr -> DECODE,JALRADR,JAL,ALUWB; JAL pc_write=1 with a=01, b=10.
//  5. op 0000000: with ILLEGAL_TRAP_EN -> illegal_o=1 held 20 cycles until rst_i; without it -> FETCH next, no retire.
//  6. rst_i pulsed mid-MEMWRITE, ready low -> mem_req/mem_write drop same cycle; instret=0; FETCH after release.
//     Force instret all-ones, retire once -> wraps to 0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle RV32I main sequencing FSM: fetch/decode/execute/writeback over one shared memory port.
// Build option ILLEGAL_TRAP_EN: an illegal decode enters a sticky TRAP state instead of acting as a NOP.
module multicycle_controller #(
  parameter int RETIRE_CNT_W = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [6:0]              op_i,
  input  logic [2:0]              funct3_i,
  input  logic                    funct7b5_i,
  input  logic                    zero_i,
  input  logic                    mem_ready_i,
  output logic                    mem_req_o,
  output logic                    mem_write_o,
  output logic                    adr_src_o,
  output logic                    ir_write_o,
  output logic                    pc_write_o,
  output logic                    reg_write_o,
  output logic [1:0]              result_src_o,
  output logic [1:0]              alu_src_a_o,
  output logic [1:0]              alu_src_b_o,
  output logic [1:0]              alu_op_o,
  output logic [1:0]              op_funct7_o,
  output logic                    instr_retired_o,
  output logic [RETIRE_CNT_W-1:0] instret_o,
  output logic                    illegal_o
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_LUI,
    S_ALUWB,
    S_BRANCH,
    S_JALRADR,
    S_JAL
`ifdef ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

`ifdef ILLEGAL_TRAP_EN
  localparam state_t ILLEGAL_NXT = S_TRAP;
`else
  localparam state_t ILLEGAL_NXT = S_FETCH;
`endif

  state_t                  state, state_nxt;
  logic                    mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic                    retire, illegal;
  logic [1:0]              result_src, alu_src_a, alu_src_b, alu_op;
  logic [RETIRE_CNT_W-1:0] instret_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       instret_q <= '0;
    else if (retire) instret_q <= instret_q + RETIRE_CNT_W'(1);
  end

  always_comb begin
    state_nxt  = state;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready_i) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch/jump target is precomputed from OldPC + imm into ALUOut
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op_i)
          7'b0000011, 7'b0100011: state_nxt = S_MEMADR;
          7'b0110011:             state_nxt = S_EXECR;
          7'b0010011:             state_nxt = S_EXECI;
          7'b1100011:             state_nxt = (funct3_i[2:1] == 2'b00) ? S_BRANCH : ILLEGAL_NXT;
          7'b1101111:             state_nxt = S_JAL;
          7'b1100111:             state_nxt = S_JALRADR;
          7'b0110111:             state_nxt = S_LUI;
          default:                state_nxt = ILLEGAL_NXT;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_nxt = op_i[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready_i) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready_i) begin
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_nxt = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_nxt = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        // beq takes on zero, bne on non-zero
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = zero_i ^ funct3_i[0];
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_JALRADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_nxt = S_JAL;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_nxt = S_ALUWB;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        illegal   = 1'b1;
        state_nxt = S_TRAP;
      end
`endif
      default: state_nxt = S_FETCH;
    endcase
  end

  // Reset forces every output low, even though the state register already sits in FETCH
  assign mem_req_o       = mem_req & ~rst_i;
  assign mem_write_o     = mem_write & ~rst_i;
  assign adr_src_o       = adr_src & ~rst_i;
  assign ir_write_o      = ir_write & ~rst_i;
  assign pc_write_o      = pc_write & ~rst_i;
  assign reg_write_o     = reg_write & ~rst_i;
  assign instr_retired_o = retire & ~rst_i;
  assign illegal_o       = illegal & ~rst_i;
  assign result_src_o    = rst_i ? 2'b00 : result_src;
  assign alu_src_a_o     = rst_i ? 2'b00 : alu_src_a;
  assign alu_src_b_o     = rst_i ? 2'b00 : alu_src_b;
  assign alu_op_o        = rst_i ? 2'b00 : alu_op;
  assign op_funct7_o     = rst_i ? 2'b00 : {op_i[5], funct7b5_i};
  assign instret_o       = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle control-output signatures and retire counting.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  op = 7'd0;
  logic [2:0]  f3 = 3'd0;
  logic        f7b5 = 1'b0;
  logic        zero = 1'b0;
  logic        ready = 1'b1;

  logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, retired, illegal;
  logic [1:0]  result_src, alu_src_a, alu_src_b, alu_op, op_funct7;
  logic [31:0] instret;

  logic        s_mem_req, s_mem_write, s_adr_src, s_ir_write, s_pc_write, s_reg_write, s_retired, s_illegal;
  logic [1:0]  s_result_src, s_alu_src_a, s_alu_src_b, s_alu_op, s_op_funct7;
  logic [1:0]  s_instret;

  int checks = 0;
  int failures = 0;
  int exp_ret = 0;

  // {req, write, adr_src, ir_write, pc_write, reg_write, result_src, a, b, alu_op, retired, illegal}
  logic [15:0] sig;
  assign sig = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                result_src, alu_src_a, alu_src_b, alu_op, retired, illegal};

  localparam logic [15:0] E_FETCH     = {6'b100110, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00};
  localparam logic [15:0] E_DECODE    = {6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
  localparam logic [15:0] E_EXECR     = {6'b000000, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
  localparam logic [15:0] E_LUI       = {6'b000000, 2'b00, 2'b11, 2'b01, 2'b00, 2'b00};
  localparam logic [15:0] E_ALUWB     = {6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [15:0] E_MEMADR    = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00};
  localparam logic [15:0] E_MEMREAD   = {6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [15:0] E_MEMWB     = {6'b000001, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [15:0] E_MEMWR_W   = {6'b111000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [15:0] E_MEMWR_D   = {6'b111000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [15:0] E_BR_TAKEN  = {6'b000010, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10};
  localparam logic [15:0] E_BR_NOT    = {6'b000000, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10};
  localparam logic [15:0] E_JALRADR   = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00};
  localparam logic [15:0] E_JAL       = {6'b000010, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
  localparam logic [15:0] E_TRAP      = {6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};

  multicycle_controller #(.RETIRE_CNT_W(32)) u_dut (
    .clk_i(clk), .rst_i(rst), .op_i(op), .funct3_i(f3), .funct7b5_i(f7b5),
    .zero_i(zero), .mem_ready_i(ready),
    .mem_req_o(mem_req), .mem_write_o(mem_write), .adr_src_o(adr_src),
    .ir_write_o(ir_write), .pc_write_o(pc_write), .reg_write_o(reg_write),
    .result_src_o(result_src), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b),
    .alu_op_o(alu_op), .op_funct7_o(op_funct7), .instr_retired_o(retired),
    .instret_o(instret), .illegal_o(illegal)
  );

  // Narrow counter instance shares all inputs so its wrap can be reached in a few instructions
  multicycle_controller #(.RETIRE_CNT_W(2)) u_small (
    .clk_i(clk), .rst_i(rst), .op_i(op), .funct3_i(f3), .funct7b5_i(f7b5),
    .zero_i(zero), .mem_ready_i(ready),
    .mem_req_o(s_mem_req), .mem_write_o(s_mem_write), .adr_src_o(s_adr_src),
    .ir_write_o(s_ir_write), .pc_write_o(s_pc_write), .reg_write_o(s_reg_write),
    .result_src_o(s_result_src), .alu_src_a_o(s_alu_src_a), .alu_src_b_o(s_alu_src_b),
    .alu_op_o(s_alu_op), .op_funct7_o(s_op_funct7), .instr_retired_o(s_retired),
    .instret_o(s_instret), .illegal_o(s_illegal)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ready = 1'b1;
    op = 7'd0; f7b5 = 1'b0;
    repeat (3) next_cycle();
    checks++; if (sig !== 16'h0) begin failures++; $display("FAIL reset_outputs got=%h want=%h", sig, 16'h0); end
    checks++; if (instret !== 32'd0) begin failures++; $display("FAIL reset_instret got=%0d want=0", instret); end
    checks++; if (s_instret !== 2'd0) begin failures++; $display("FAIL reset_small_instret got=%0d want=0", s_instret); end
    rst = 1'b0;
  endtask

  task automatic test_alu();
    logic [15:0] ev [2][4];
    logic [6:0]  ops [2];
    ev  = '{'{E_FETCH, E_DECODE, E_EXECR, E_ALUWB}, '{E_FETCH, E_DECODE, E_LUI, E_ALUWB}};
    ops = '{7'b0110011, 7'b0110111};
    f7b5 = 1'b1; f3 = 3'b000; ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      op = ops[k];
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        checks++; if (sig !== ev[k][i]) begin failures++; $display("FAIL alu%0d_cycle%0d got=%h want=%h", k, i, sig, ev[k][i]); end
        if (k == 0 && i == 2) begin
          checks++; if (op_funct7 !== 2'b11) begin failures++; $display("FAIL add_op_funct7 got=%b want=11", op_funct7); end
        end
        if (i == 3) begin
          checks++; if (instret !== 32'(exp_ret)) begin failures++; $display("FAIL alu%0d_instret_before got=%0d want=%0d", k, instret, exp_ret); end
        end
        next_cycle();
      end
      exp_ret++;
      checks++; if (instret !== 32'(exp_ret)) begin failures++; $display("FAIL alu%0d_instret_after got=%0d want=%0d", k, instret, exp_ret); end
      checks++; if (s_instret !== 2'(exp_ret)) begin failures++; $display("FAIL alu%0d_small_instret got=%0d want=%0d", k, s_instret, exp_ret % 4); end
    end
  endtask

  task automatic test_load();
    logic [15:0] ev [8];
    logic        rdy [8];
    ev  = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMREAD, E_MEMREAD, E_MEMREAD, E_MEMREAD, E_MEMWB};
    rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    op = 7'b0000011; f7b5 = 1'b0; f3 = 3'b010;
    for (int i = 0; i < 8; i++) begin
      ready = rdy[i];
      @(negedge clk);
      checks++; if (sig !== ev[i]) begin failures++; $display("FAIL load_cycle%0d got=%h want=%h", i, sig, ev[i]); end
      next_cycle();
    end
    ready = 1'b1;
    exp_ret++;
    checks++; if (instret !== 32'(exp_ret)) begin failures++; $display("FAIL load_instret got=%0d want=%0d", instret, exp_ret); end
  endtask

  task automatic test_store();
    logic [15:0] ev [4];
    ev = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWR_D};
    op = 7'b0100011; ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (sig !== ev[i]) begin failures++; $display("FAIL store_cycle%0d got=%h want=%h", i, sig, ev[i]); end
      next_cycle();
    end
    exp_ret++;
    checks++; if (instret !== 32'(exp_ret)) begin failures++; $display("FAIL store_instret got=%0d want=%0d", instret, exp_ret); end
  endtask

  task automatic test_branch();
    logic [2:0]  f3s [3];
    logic        zs [3];
    logic [15:0] last [3];
    f3s  = '{3'b000, 3'b001, 3'b001};
    zs   = '{1'b1, 1'b1, 1'b0};
    last = '{E_BR_TAKEN, E_BR_NOT, E_BR_TAKEN};
    op = 7'b1100011; ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      f3 = f3s[k]; zero = zs[k];
      @(negedge clk);
      checks++; if (sig !== E_FETCH) begin failures++; $display("FAIL branch%0d_fetch got=%h want=%h", k, sig, E_FETCH); end
      next_cycle();
      @(negedge clk);
      checks++; if (sig !== E_DECODE) begin failures++; $display("FAIL branch%0d_decode got=%h want=%h", k, sig, E_DECODE); end
      next_cycle();
      @(negedge clk);
      checks++; if (sig !== last[k]) begin failures++; $display("FAIL branch%0d_exec got=%h want=%h", k, sig, last[k]); end
      next_cycle();
      exp_ret++;
      checks++; if (instret !== 32'(exp_ret)) begin failures++; $display("FAIL branch%0d_instret got=%0d want=%0d", k, instret, exp_ret); end
    end
    zero = 1'b0; f3 = 3'b000;
  endtask

  task automatic test_jalr();
    logic [15:0] ev [5];
    ev = '{E_FETCH, E_DECODE, E_JALRADR, E_JAL, E_ALUWB};
    op = 7'b1100111; ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (sig !== ev[i]) begin failures++; $display("FAIL jalr_cycle%0d got=%h want=%h", i, sig, ev[i]); end
      next_cycle();
    end
    exp_ret++;
    checks++; if (instret !== 32'(exp_ret)) begin failures++; $display("FAIL jalr_instret got=%0d want=%0d", instret, exp_ret); end
  endtask

  task automatic test_illegal();
    logic [6:0] ops [2];
    logic [2:0] f3s [2];
    ops = '{7'b0000000, 7'b1100011};
    f3s = '{3'b000, 3'b010};
    ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      op = ops[k]; f3 = f3s[k];
      @(negedge clk);
      checks++; if (sig !== E_FETCH) begin failures++; $display("FAIL illegal%0d_fetch got=%h want=%h", k, sig, E_FETCH); end
      next_cycle();
      @(negedge clk);
      checks++; if (sig !== E_DECODE) begin failures++; $display("FAIL illegal%0d_decode got=%h want=%h", k, sig, E_DECODE); end
      next_cycle();
`ifdef ILLEGAL_TRAP_EN
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        checks++; if (sig !== E_TRAP) begin failures++; $display("FAIL illegal%0d_trap%0d got=%h want=%h", k, i, sig, E_TRAP); end
        next_cycle();
      end
      checks++; if (instret !== 32'(exp_ret)) begin failures++; $display("FAIL illegal%0d_trap_instret got=%0d want=%0d", k, instret, exp_ret); end
      rst = 1'b1;
      #1;
      checks++; if (sig !== 16'h0) begin failures++; $display("FAIL illegal%0d_trap_reset got=%h want=0", k, sig); end
      next_cycle();
      rst = 1'b0;
      exp_ret = 0;
`else
      checks++; if (instret !== 32'(exp_ret)) begin failures++; $display("FAIL illegal%0d_nop_instret got=%0d want=%0d", k, instret, exp_ret); end
`endif
    end
    f3 = 3'b000;
    @(negedge clk);
    checks++; if (sig !== E_FETCH) begin failures++; $display("FAIL illegal_refetch got=%h want=%h", sig, E_FETCH); end
    next_cycle();
    op = 7'b0110011;
    repeat (3) next_cycle();
    exp_ret++;
    checks++; if (instret !== 32'(exp_ret)) begin failures++; $display("FAIL illegal_recover_instret got=%0d want=%0d", instret, exp_ret); end
  endtask

  task automatic test_reset_mid();
    op = 7'b0100011; ready = 1'b1;
    next_cycle();
    ready = 1'b0;
    repeat (2) next_cycle();
    @(negedge clk);
    checks++; if (sig !== E_MEMWR_W) begin failures++; $display("FAIL rstmid_memwrite got=%h want=%h", sig, E_MEMWR_W); end
    #1 rst = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0 || mem_write !== 1'b0) begin failures++; $display("FAIL rstmid_drop got=%b%b want=00", mem_req, mem_write); end
    checks++; if (instret !== 32'd0) begin failures++; $display("FAIL rstmid_instret got=%0d want=0", instret); end
    next_cycle();
    checks++; if (sig !== 16'h0) begin failures++; $display("FAIL rstmid_held got=%h want=0", sig); end
    rst = 1'b0;
    ready = 1'b1;
    exp_ret = 0;
    @(negedge clk);
    checks++; if (sig !== E_FETCH) begin failures++; $display("FAIL rstmid_refetch got=%h want=%h", sig, E_FETCH); end
    next_cycle();
    op = 7'b0110011;
    repeat (3) next_cycle();
  endtask

  task automatic test_wrap();
    // The preceding add retired after reset; three more bring the 2-bit counter round to zero
    exp_ret = 1;
    op = 7'b0110011; ready = 1'b1;
    checks++; if (s_instret !== 2'd1) begin failures++; $display("FAIL wrap_start got=%0d want=1", s_instret); end
    for (int k = 0; k < 3; k++) begin
      repeat (4) next_cycle();
      exp_ret++;
      checks++; if (s_instret !== 2'(exp_ret)) begin failures++; $display("FAIL wrap_small%0d got=%0d want=%0d", k, s_instret, exp_ret % 4); end
      checks++; if (instret !== 32'(exp_ret)) begin failures++; $display("FAIL wrap_big%0d got=%0d want=%0d", k, instret, exp_ret); end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_branch();
    test_jalr();
    test_illegal();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
